cpu_controller: RTL

Microsequencer for the 8-bit bus CPU. Tracks instruction fetch/execute steps and drives the load/drive enables of every bus-attached register, the program counter, RAM and ALU so that each instruction executes as a fixed micro-step sequence. Guarantees exactly zero or one bus driver per cycle. Sits beside the instruction register and consumes its opcode nibble and the ALU flags.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cpu_microcode.sv | 88 ++++++++
 rtl/cpu_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, step and control-word definitions for the bus CPU
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam step_t LAST_STEP_SHORT = T2;
  localparam step_t LAST_STEP_MEM   = T3;
  localparam step_t LAST_STEP_ALU   = T4;

  typedef struct packed {
    logic pc_out;
    logic ram_out;
    logic ir_out;
    logic a_out;
    logic alu_out;
    logic mar_in;
    logic ram_in;
    logic ir_in;
    logic a_in;
    logic b_in;
    logic out_in;
    logic pc_inc;
    logic pc_jump;
    logic alu_sub;
    logic flags_in;
  } ctrl_t;

  function automatic step_t last_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: return LAST_STEP_MEM;
      OP_ADD, OP_SUB: return LAST_STEP_ALU;
      default:        return LAST_STEP_SHORT;
    endcase
  endfunction

endpackage

// File: rtl/cpu_microcode.sv
// rtl/cpu_microcode.sv - combinational (step, opcode, flags) to control word decoder
module cpu_microcode
  import cpu_pkg::*;
(
  input  step_t       step,
  input  logic [3:0]  opcode,
  input  logic        carry,
  input  logic        zero,
  output ctrl_t       ctrl,
  output logic        last,
  output logic        halt
);

  always_comb begin
    ctrl = '0;
    case (step)
      T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
      end
      T1: begin
        ctrl.ram_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.pc_inc  = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_out = 1'b1;
            ctrl.mar_in = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_out = 1'b1;
            ctrl.a_in   = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_jump = 1'b1;
          end
          OP_JC: begin
            ctrl.ir_out  = carry;
            ctrl.pc_jump = carry;
          end
          OP_JZ: begin
            ctrl.ir_out  = zero;
            ctrl.pc_jump = zero;
          end
          OP_OUT: begin
            ctrl.a_out  = 1'b1;
            ctrl.out_in = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_out = 1'b1;
            ctrl.a_in    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_out = 1'b1;
            ctrl.b_in    = 1'b1;
          end
          OP_STA: begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_in = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl.alu_out  = 1'b1;
          ctrl.a_in     = 1'b1;
          ctrl.flags_in = 1'b1;
          ctrl.alu_sub  = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // '>=' also retires any step past the opcode's end, so the counter can never run away
  assign last = (step >= last_step(opcode));
  assign halt = last && (opcode == OP_HLT);

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - microsequencer: step counter, HALTED, flags, output gating (CPU_COND_JUMP_EN)
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       pc_out,
  output logic       ram_out,
  output logic       ir_out,
  output logic       a_out,
  output logic       alu_out,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ir_in,
  output logic       a_in,
  output logic       b_in,
  output logic       out_in,
  output logic       pc_inc,
  output logic       pc_jump,
  output logic       alu_sub,
  output logic       flags_in,
  output logic       halted
);

`ifdef CPU_COND_JUMP_EN
  localparam logic FLAGS_EN = 1'b1;
`else
  localparam logic FLAGS_EN = 1'b0;
`endif

  step_t step, step_nxt;
  logic  halted_nxt;
  logic  carry_q, zero_q;
  logic  last, halt, active;
  ctrl_t ctrl, ctrl_g;

  cpu_microcode u_microcode (
    .step   (step),
    .opcode (opcode),
    .carry  (carry_q),
    .zero   (zero_q),
    .ctrl   (ctrl),
    .last   (last),
    .halt   (halt)
  );

  assign active = !rst && run && !halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step   <= T0;
      halted <= 1'b0;
    end else begin
      step   <= step_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    step_nxt   = step;
    halted_nxt = halted;
    if (run && !halted) begin
      if (last) begin
        step_nxt   = T0;
        halted_nxt = halt;
      end else begin
        case (step)
          T0:      step_nxt = T1;
          T1:      step_nxt = T2;
          T2:      step_nxt = T3;
          T3:      step_nxt = T4;
          default: step_nxt = T0;
        endcase
      end
    end
  end

`ifdef CPU_COND_JUMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (active && ctrl.flags_in) begin
      carry_q <= alu_carry;
      zero_q  <= alu_zero;
    end
  end
`else
  // without the flag register JC/JZ always decode as not-taken
  logic unused_alu_flags;
  assign carry_q          = 1'b0;
  assign zero_q           = 1'b0;
  assign unused_alu_flags = alu_carry ^ alu_zero;
`endif

  assign ctrl_g = active ? ctrl : '0;

  assign pc_out   = ctrl_g.pc_out;
  assign ram_out  = ctrl_g.ram_out;
  assign ir_out   = ctrl_g.ir_out;
  assign a_out    = ctrl_g.a_out;
  assign alu_out  = ctrl_g.alu_out;
  assign mar_in   = ctrl_g.mar_in;
  assign ram_in   = ctrl_g.ram_in;
  assign ir_in    = ctrl_g.ir_in;
  assign a_in     = ctrl_g.a_in;
  assign b_in     = ctrl_g.b_in;
  assign out_in   = ctrl_g.out_in;
  assign pc_inc   = ctrl_g.pc_inc;
  assign pc_jump  = ctrl_g.pc_jump;
  assign alu_sub  = ctrl_g.alu_sub;
  assign flags_in = ctrl_g.flags_in & FLAGS_EN;

endmodule
